// File: rtl/uart_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_dbg_pkg
//  Description : Shared constants and types for the UART debug bus master:
//                command opcodes, response bytes and the FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_dbg_pkg;

    // Command opcodes received from the host
    localparam logic [7:0] CMD_READ    = 8'h52;  // 'R'
    localparam logic [7:0] CMD_WRITE   = 8'h57;  // 'W'

    // Response bytes returned to the host
    localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_BADCMD  = 8'h3F;  // '?'
    localparam logic [7:0] RSP_TIMEOUT = 8'h45;  // 'E'

    // Command FSM states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        BUS  = 3'd3,
        RESP = 3'd4
    } dbg_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_dbg_phy.sv
`default_nettype none
// ============================================================================
//  Module      : uart_dbg_phy
//  Description : 8N1 UART receive and transmit serializers for the debug
//                bridge. One bit lasts CLK_DIV+1 clock cycles.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk          in   system clock
//    rst          in   asynchronous active-high reset
//    i_rx         in   serial input, idle high
//    o_rx_data    out  last received byte (valid with o_byte_valid)
//    o_byte_valid out  one-cycle pulse: byte received with good stop bit
//    o_frame_err  out  one-cycle pulse: stop bit sampled low
//    o_tx         out  serial output, idle high
//    i_tx_data    in   byte to transmit
//    i_tx_start   in   transmit request, accepted only while o_tx_ready
//    o_tx_ready   out  transmitter idle
// ============================================================================
module uart_dbg_phy #(
    parameter logic [15:0] CLK_DIV = 16'd103
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_rx_data,
    output logic       o_byte_valid,
    output logic       o_frame_err,
    output logic       o_tx,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_start,
    output logic       o_tx_ready
);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic        r_rx_s1;
    logic        r_rx_s2;
    logic [15:0] r_rx_cnt;
    logic [3:0]  r_rx_bits;     // 0 = idle, 10 = start bit, 1 = stop bit
    logic [7:0]  r_rx_shift;
    logic        r_byte_valid;
    logic        r_frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1      <= 1'b1;
            r_rx_s2      <= 1'b1;
            r_rx_cnt     <= 16'd0;
            r_rx_bits    <= 4'd0;
            r_rx_shift   <= 8'd0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            // Two-flop synchronizer: the line is asynchronous to clk
            r_rx_s1      <= i_rx;
            r_rx_s2      <= r_rx_s1;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_rx_bits == 4'd0) begin
                // Half-bit delay puts every later sample near mid-bit
                if (!r_rx_s2) begin
                    r_rx_cnt  <= CLK_DIV >> 1;
                    r_rx_bits <= 4'd10;
                end
            end else if (r_rx_cnt != 16'd0) begin
                r_rx_cnt <= r_rx_cnt - 16'd1;
            end else begin
                r_rx_cnt  <= CLK_DIV;
                r_rx_bits <= r_rx_bits - 4'd1;
                if (r_rx_bits == 4'd10) begin
                    // Start bit gone high again: line glitch, not a frame
                    if (r_rx_s2) begin
                        r_rx_bits <= 4'd0;
                    end
                end else if (r_rx_bits == 4'd1) begin
                    if (r_rx_s2) begin
                        r_byte_valid <= 1'b1;
                    end else begin
                        r_frame_err  <= 1'b1;
                    end
                end else begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                end
            end
        end
    end

    assign o_rx_data    = r_rx_shift;
    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;

    // ------------------------------------------------------------------
    // Transmitter: ones are shifted in behind the frame so the line
    // output is taken straight from a flop and idles high.
    // ------------------------------------------------------------------
    logic [9:0]  r_tx_shift;
    logic [3:0]  r_tx_bits;
    logic [15:0] r_tx_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_shift <= '1;
            r_tx_bits  <= 4'd0;
            r_tx_cnt   <= 16'd0;
        end else if (r_tx_bits == 4'd0) begin
            if (i_tx_start) begin
                r_tx_shift <= {1'b1, i_tx_data, 1'b0};
                r_tx_bits  <= 4'd10;
                r_tx_cnt   <= CLK_DIV;
            end
        end else if (r_tx_cnt != 16'd0) begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
        end else begin
            r_tx_shift <= {1'b1, r_tx_shift[9:1]};
            r_tx_bits  <= r_tx_bits - 4'd1;
            r_tx_cnt   <= CLK_DIV;
        end
    end

    assign o_tx       = r_tx_shift[0];
    assign o_tx_ready = (r_tx_bits == 4'd0);

endmodule
`default_nettype wire

// File: rtl/uart_dbg_master.sv
`default_nettype none
// ============================================================================
//  Module      : uart_dbg_master
//  Description : UART-to-memory-bus debug bridge. Decodes 'R'/'W' commands
//                received over 8N1 serial, performs one 32-bit bus access
//                per command and returns data ('R') or 'K' ('W'); unknown
//                opcodes are answered with '?'.
//  Revision    : 1.0 - initial release
//
//  Configuration macro
//    UART_DBG_TIMEOUT_EN : when defined, a bus access not completed within
//                          TIMEOUT_CYCLES cycles is abandoned and 'E' is
//                          returned. When undefined the bus phase waits
//                          indefinitely.
//
//  Ports
//    clk             in   system clock
//    reset           in   asynchronous active-high reset
//    rx_in           in   serial command input, idle high
//    tx_out          out  serial response output, idle high
//    address_out     out  bus address, [1:0] always 0
//    sel_out         out  bus request
//    read_out        out  read strobe (with sel_out on reads)
//    write_mask_out  out  byte enables, 4'b1111 on writes
//    write_value_out out  write data
//    read_value_in   in   read data, valid with ready_in
//    ready_in        in   bus completion
//    busy_out        out  command in progress (FSM not IDLE)
// ============================================================================
module uart_dbg_master
    import uart_dbg_pkg::*;
#(
    parameter logic [15:0] CLK_DIV        = 16'd103,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_in,
    output logic        tx_out,
    output logic [31:0] address_out,
    output logic        sel_out,
    output logic        read_out,
    output logic [3:0]  write_mask_out,
    output logic [31:0] write_value_out,
    input  logic [31:0] read_value_in,
    input  logic        ready_in,
    output logic        busy_out
);

    dbg_state_t  r_state;
    dbg_state_t  w_state_next;

    logic [1:0]  r_idx;
    logic        r_is_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_resp;        // response bytes, next one in [7:0]
    logic [2:0]  r_resp_left;
    logic        r_pend_bad;    // '?' waiting for the transmitter

    logic [7:0]  w_rx_data;
    logic        w_byte_valid;
    logic        w_frame_err;
    logic        w_tx_ready;
    logic        w_tx_start;
    logic [7:0]  w_tx_data;
    logic        w_pend_fire;
    logic        w_resp_fire;
    logic        w_is_cmd;
    logic        w_bus_done;
    logic        w_bus_timeout;

    uart_dbg_phy #(
        .CLK_DIV (CLK_DIV)
    ) u_phy (
        .clk          (clk),
        .rst          (reset),
        .i_rx         (rx_in),
        .o_rx_data    (w_rx_data),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err),
        .o_tx         (tx_out),
        .i_tx_data    (w_tx_data),
        .i_tx_start   (w_tx_start),
        .o_tx_ready   (w_tx_ready)
    );

`ifdef UART_DBG_TIMEOUT_EN
    localparam int c_to_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_to_w-1:0] r_to_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (r_state == BUS) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    // A ready_in arriving on the expiry cycle takes priority
    assign w_bus_timeout = (r_state == BUS) && !ready_in &&
                           (r_to_cnt == c_to_w'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_bus_timeout    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and transmit arbitration. A pending '?' is drained
    // ahead of any command response.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_is_cmd     = (w_rx_data == CMD_READ) || (w_rx_data == CMD_WRITE);
        w_bus_done   = (r_state == BUS) && ready_in;
        w_tx_start   = r_pend_bad || (r_state == RESP);
        w_tx_data    = r_pend_bad ? RSP_BADCMD : r_resp[7:0];
        w_pend_fire  = r_pend_bad && w_tx_ready;
        w_resp_fire  = (r_state == RESP) && w_tx_ready && !r_pend_bad;

        unique case (r_state)
            IDLE: begin
                if (w_byte_valid && w_is_cmd) begin
                    w_state_next = ADDR;
                end
            end
            ADDR: begin
                if (w_frame_err) begin
                    w_state_next = IDLE;
                end else if (w_byte_valid && (r_idx == 2'd3)) begin
                    w_state_next = r_is_write ? DATA : BUS;
                end
            end
            DATA: begin
                if (w_frame_err) begin
                    w_state_next = IDLE;
                end else if (w_byte_valid && (r_idx == 2'd3)) begin
                    w_state_next = BUS;
                end
            end
            BUS: begin
                if (w_bus_done || w_bus_timeout) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (w_resp_fire && (r_resp_left == 3'd1)) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx       <= 2'd0;
            r_is_write  <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_resp      <= 32'd0;
            r_resp_left <= 3'd0;
            r_pend_bad  <= 1'b0;
        end else begin
            if (w_pend_fire) begin
                r_pend_bad <= 1'b0;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_byte_valid) begin
                        if (w_is_cmd) begin
                            r_is_write <= (w_rx_data == CMD_WRITE);
                            r_idx      <= 2'd0;
                        end else begin
                            r_pend_bad <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (w_byte_valid) begin
                        // Bus is word-addressed: drop the two low bits
                        r_addr[{r_idx, 3'b000} +: 8] <= w_rx_data &
                            ((r_idx == 2'd0) ? 8'hFC : 8'hFF);
                        r_idx <= r_idx + 2'd1;
                    end
                end
                DATA: begin
                    if (w_byte_valid) begin
                        r_wdata[{r_idx, 3'b000} +: 8] <= w_rx_data;
                        r_idx <= r_idx + 2'd1;
                    end
                end
                BUS: begin
                    if (w_bus_done) begin
                        r_resp      <= r_is_write ? {24'd0, RSP_OK} : read_value_in;
                        r_resp_left <= r_is_write ? 3'd1 : 3'd4;
                    end else if (w_bus_timeout) begin
                        r_resp      <= {24'd0, RSP_TIMEOUT};
                        r_resp_left <= 3'd1;
                    end
                end
                RESP: begin
                    if (w_resp_fire) begin
                        r_resp      <= {8'd0, r_resp[31:8]};
                        r_resp_left <= r_resp_left - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs decode directly from the state flop so that an
    // asynchronous reset removes the request immediately.
    assign sel_out         = (r_state == BUS);
    assign read_out        = sel_out && !r_is_write;
    assign write_mask_out  = (sel_out && r_is_write) ? 4'b1111 : 4'b0000;
    assign address_out     = r_addr;
    assign write_value_out = r_wdata;
    assign busy_out        = (r_state != IDLE);

endmodule
`default_nettype wire
